// File: rtl/instr_encoder_fifo.sv
// Packs decoded instruction fields into 32-bit decode-stage words and buffers
// them in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
module instr_encoder_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_data_src,
    input  logic [2:0]        in_alu_op,
    input  logic [4:0]        in_wsel,
    input  logic [4:0]        in_rsel1,
    input  logic [4:0]        in_rsel2,
    input  logic [15:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr_out,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [31:0]       enc_word;
    logic              push;
    logic              pop;

    // Field packing: the immediate and rsel2 share the low half; the unused
    // one is dropped rather than merged.
    always_comb begin
        enc_word         = '0;
        enc_word[29]     = in_data_src;
        enc_word[28:26]  = in_alu_op;
        enc_word[25:21]  = in_wsel;
        enc_word[20:16]  = in_rsel1;
        if (in_data_src) begin
            enc_word[15:0] = in_imm;
        end else begin
            enc_word[15:11] = in_rsel2;
        end
    end

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready and out_valid depend only on the registered count, so neither
    // side sees a combinational path from the other side's signals.
    assign in_ready  = (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign instr_out = out_valid ? mem[rd_ptr] : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= enc_word;
        end
    end

endmodule

// File: tb/tb_instr_encoder_fifo.sv
// Self-checking bench for instr_encoder_fifo: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_instr_encoder_fifo;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_data_src;
    logic [2:0]        in_alu_op;
    logic [4:0]        in_wsel;
    logic [4:0]        in_rsel1;
    logic [4:0]        in_rsel2;
    logic [15:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       instr_out;
    logic [ADDR_W:0]   count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    instr_encoder_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data_src (in_data_src),
        .in_alu_op   (in_alu_op),
        .in_wsel     (in_wsel),
        .in_rsel1    (in_rsel1),
        .in_rsel2    (in_rsel2),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr_out   (instr_out),
        .count       (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ds;
        logic [2:0]  op;
        logic [4:0]  wsel;
        logic [4:0]  rsel1;
        logic [4:0]  rsel2;
        logic [15:0] imm;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[7];

    // reference packing computed with plain arithmetic on field weights
    function automatic logic [31:0] pack_ref(input logic ds, input logic [2:0] op,
                                             input logic [4:0] ws, input logic [4:0] r1,
                                             input logic [4:0] r2, input logic [15:0] imm);
        int unsigned low;
        int unsigned v;
        low = ds ? 32'(imm) : 32'(r2) * 32'd2048;
        v = 32'(ds) * 32'd536870912 + 32'(op) * 32'd67108864
          + 32'(ws) * 32'd2097152 + 32'(r1) * 32'd65536 + low;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // compare all outputs against the scoreboard queue
    task automatic check_outputs(input string tag);
        int sz;
        sz = exp_q.size();
        check({tag, " count"}, 32'(count), 32'(sz));
        check({tag, " out_valid"}, 32'(out_valid), 32'(sz != 0));
        check({tag, " in_ready"}, 32'(in_ready), 32'(sz < DEPTH));
        check({tag, " instr_out"}, instr_out, (sz != 0) ? exp_q[0] : 32'h0);
    endtask

    task automatic drive_fields(input logic ds, input logic [2:0] op, input logic [4:0] ws,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [15:0] imm);
        in_data_src = ds;
        in_alu_op   = op;
        in_wsel     = ws;
        in_rsel1    = r1;
        in_rsel2    = r2;
        in_imm      = imm;
    endtask

    task automatic drive_random_fields();
        drive_fields(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)));
    endtask

    // advance one clock edge and update the model with what the edge should do
    task automatic tick();
        bit do_push;
        bit do_pop;
        bit do_flush;
        logic [31:0] w;
        do_flush = flush;
        do_push  = in_valid && (exp_q.size() < DEPTH);
        do_pop   = out_ready && (exp_q.size() != 0);
        w = pack_ref(in_data_src, in_alu_op, in_wsel, in_rsel1, in_rsel2, in_imm);
        @(posedge clk);
        #1;
        if (do_flush) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(w);
        end
    endtask

    task automatic push_word();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        drive_random_fields();
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 3'b010, 5'd3,  5'd1,  5'd0,  16'h00FF, 32'h286100FF};
        vecs[1] = '{1'b0, 3'b001, 5'd5,  5'd2,  5'd7,  16'hFFFF, 32'h04A23800};
        vecs[2] = '{1'b1, 3'b111, 5'd31, 5'd31, 5'd31, 16'hFFFF, 32'h3FFFFFFF};
        vecs[3] = '{1'b0, 3'b111, 5'd31, 5'd31, 5'd31, 16'hFFFF, 32'h1FFFF800};
        vecs[4] = '{1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  16'h1234, 32'h00000000};
        vecs[5] = '{1'b1, 3'b000, 5'd0,  5'd0,  5'd0,  16'h0000, 32'h20000000};
        vecs[6] = '{1'b1, 3'b100, 5'd16, 5'd8,  5'd3,  16'hA5A5, 32'h3208A5A5};

        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive_fields(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b1;
        tick();
        check_outputs("after release");

        // table vectors: push into empty FIFO, check the packed word, pop it
        for (int i = 0; i < 7; i++) begin
            drive_fields(vecs[i].ds, vecs[i].op, vecs[i].wsel, vecs[i].rsel1, vecs[i].rsel2, vecs[i].imm);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d word", i), instr_out, vecs[i].exp_word);
            check($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d count", i), 32'(count), 32'd1);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check_outputs($sformatf("vec%0d pop", i));
        end

        // fill to full, hold, refuse a fifth push, then pop with in_valid high
        for (int i = 0; i < DEPTH; i++) push_word();
        check_outputs("full");
        check("full count", 32'(count), 32'd4);
        check("full in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        drive_random_fields();
        tick();
        check_outputs("full hold");
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_outputs("pop while full");
        check("pop while full in_ready", 32'(in_ready), 32'd1);

        // drain, then simultaneous push/pop at count=2
        out_ready = 1'b1;
        while (exp_q.size() != 0) tick();
        out_ready = 1'b0;
        push_word();
        push_word();
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            drive_random_fields();
            tick();
            check_outputs($sformatf("pushpop%0d", i));
            check($sformatf("pushpop%0d count", i), 32'(count), 32'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // flush at count=3 overrides push and pop
        push_word();
        check_outputs("pre-flush");
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive_random_fields();
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_outputs("flush");
        check("flush count", 32'(count), 32'd0);

        // asynchronous reset mid-stream at count=2
        push_word();
        push_word();
        check_outputs("pre-reset");
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst instr_out", instr_out, 32'h0);
        check("async rst count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_outputs("post-reset");
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        // randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 2) == 0);
            flush     = 1'($urandom_range(0, 24) == 0);
            drive_random_fields();
            tick();
            check_outputs($sformatf("rand%0d", i));
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
